// File: rtl/id_hazard_ctrl.sv
// Decode-stage hazard sequencer: load-use / branch-operand stalls, branch and jump redirects, D-cache freeze.
// Optional HAZARD_PERF_EN adds stall-cycle and flush performance counters.
module id_hazard_ctrl #(
  parameter int CNT_W  = 2,
  parameter int PERF_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [31:0]       instr_i,
  input  logic              id_valid_i,
  input  logic              ex_memread_i,
  input  logic              ex_regwrite_i,
  input  logic [4:0]        ex_rd_i,
  input  logic              branch_taken_i,
  input  logic              dcache_stall_i,
  output logic              pc_write_o,
  output logic              ifid_write_o,
  output logic              ifid_flush_o,
  output logic              idex_bubble_o,
  output logic              pc_redirect_o,
  output logic [1:0]        imm_sel_o
`ifdef HAZARD_PERF_EN
  ,
  output logic [PERF_W-1:0] stall_cycles_o,
  output logic [PERF_W-1:0] flush_count_o
`endif
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef enum logic [1:0] {RUN, STALL, MEM_WAIT} state_t;

  // Whole sequencer state in one struct so checkers can bind to a single signal.
  typedef struct packed {
    state_t           state;
    state_t           saved;
    logic [CNT_W-1:0] cnt;
  } ctrl_t;

  ctrl_t ctrl_q, ctrl_d;

  logic [6:0] opcode;
  logic [4:0] rs1, rs2;
  logic       is_branch, use_rs1, use_rs2, match, redirect_cond;
  logic [1:0] need;
  state_t     eff_state;
  logic       unused_instr_bits;

  assign opcode = instr_i[6:0];
  assign rs1    = instr_i[19:15];
  assign rs2    = instr_i[24:20];
  assign unused_instr_bits = ^{instr_i[31:25], instr_i[14:7]};

  always_comb begin
    unique case (opcode)
      OP_STORE:  imm_sel_o = 2'd1;
      OP_BRANCH: imm_sel_o = 2'd2;
      OP_JAL:    imm_sel_o = 2'd3;
      default:   imm_sel_o = 2'd0;
    endcase
  end

  assign is_branch = (opcode == OP_BRANCH);
  assign use_rs1 = (opcode == OP_REG) || (opcode == OP_IMM) || (opcode == OP_LOAD) ||
                   (opcode == OP_STORE) || (opcode == OP_BRANCH) || (opcode == OP_JALR);
  assign use_rs2 = (opcode == OP_REG) || (opcode == OP_STORE) || (opcode == OP_BRANCH);
  assign match = (ex_rd_i != 5'd0) &&
                 ((use_rs1 && (ex_rd_i == rs1)) || (use_rs2 && (ex_rd_i == rs2)));
  assign redirect_cond = id_valid_i &&
                         ((is_branch && branch_taken_i) || (opcode == OP_JAL) || (opcode == OP_JALR));

  // Branches resolve in ID, so a load feeding one needs two bubbles and an ALU result one.
  always_comb begin
    need = 2'd0;
    if (ex_memread_i && match)
      need = is_branch ? 2'd2 : 2'd1;
    else if (ex_regwrite_i && match && is_branch)
      need = 2'd1;
  end

  // A miss freezes the sequencer; once the miss clears, the saved state acts in that same cycle.
  assign eff_state = (ctrl_q.state == MEM_WAIT) ? ctrl_q.saved : ctrl_q.state;

  always_comb begin
    ctrl_d        = ctrl_q;
    pc_write_o    = 1'b1;
    ifid_write_o  = 1'b1;
    ifid_flush_o  = 1'b0;
    idex_bubble_o = 1'b0;
    pc_redirect_o = 1'b0;
    if (dcache_stall_i) begin
      pc_write_o   = 1'b0;
      ifid_write_o = 1'b0;
      ctrl_d.state = MEM_WAIT;
      ctrl_d.saved = eff_state;
    end else begin
      ctrl_d.state = eff_state;
      unique case (eff_state)
        STALL: begin
          pc_write_o    = 1'b0;
          ifid_write_o  = 1'b0;
          idex_bubble_o = 1'b1;
          ctrl_d.cnt    = ctrl_q.cnt - CNT_W'(1);
          if (ctrl_q.cnt == CNT_W'(1))
            ctrl_d.state = RUN;
        end
        default: begin
          if (id_valid_i && (need != 2'd0)) begin
            pc_write_o    = 1'b0;
            ifid_write_o  = 1'b0;
            idex_bubble_o = 1'b1;
            if (need == 2'd2) begin
              ctrl_d.state = STALL;
              ctrl_d.cnt   = CNT_W'(1);
            end
          end else if (redirect_cond) begin
            pc_redirect_o = 1'b1;
            ifid_flush_o  = 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)
      ctrl_q <= '{state: RUN, saved: RUN, cnt: '0};
    else
      ctrl_q <= ctrl_d;
  end

`ifdef HAZARD_PERF_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cycles_o <= '0;
      flush_count_o  <= '0;
    end else begin
      stall_cycles_o <= stall_cycles_o + PERF_W'(idex_bubble_o);
      flush_count_o  <= flush_count_o + PERF_W'(ifid_flush_o);
    end
  end
`endif

endmodule
